// File: rtl/control_sequencer_pkg.sv
// cpu_ctrl_pkg -- shared state, opcode, ALU-op and strobe bit-index definitions for the control sequencer.
// Revision 1.0
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_INCPC = 5'd14;

  localparam int ZIN     = 18;
  localparam int YIN     = 19;
  localparam int PCIN    = 20;
  localparam int MDRIN   = 21;
  localparam int IRIN    = 24;
  localparam int MARIN   = 25;
  localparam int ZLO_OUT = 19;
  localparam int PC_OUT  = 20;
  localparam int MDR_OUT = 21;
  localparam int C_OUT   = 23;

  function automatic logic [4:0] get_opcode(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic op_is_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_NOP, OP_HALT: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Register and immediate forms of the same operation share one ALU code.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      default:         return ALU_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- IR/stop inputs and all control strobes between sequencer and datapath.
// Revision 1.0
`default_nettype none

interface control_sequencer_if #(
  parameter int CSW = 5
);
  logic [31:0]    ir;
  logic           stop;
  logic [31:0]    enable;
  logic [31:0]    busSelect;
  logic [CSW-1:0] Control_Signals;
  logic           Gra;
  logic           Grb;
  logic           Grc;
  logic           Rin;
  logic           Rout;
  logic           BAout;
  logic           MD_Read;
  logic           ReadRAM;
  logic           WriteRAM;
  logic           run;
  logic           illegal_op;

  modport master (
    input  ir, stop,
    output enable, busSelect, Control_Signals, Gra, Grb, Grc, Rin, Rout, BAout,
           MD_Read, ReadRAM, WriteRAM, run, illegal_op
  );

  modport slave (
    output ir, stop,
    input  enable, busSelect, Control_Signals, Gra, Grb, Grc, Rin, Rout, BAout,
           MD_Read, ReadRAM, WriteRAM, run, illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/control_sequencer_ctrl_decode.sv
// ctrl_decode -- Moore output decode: (state, latched opcode) to every datapath strobe.
// Revision 1.0
`default_nettype none

module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int CSW = 5
) (
  input  state_t         i_state,
  input  logic [OPW-1:0] i_opcode,
  output logic [31:0]    o_enable,
  output logic [31:0]    o_busSelect,
  output logic [CSW-1:0] o_Control_Signals,
  output logic           o_Gra,
  output logic           o_Grb,
  output logic           o_Grc,
  output logic           o_Rin,
  output logic           o_Rout,
  output logic           o_BAout,
  output logic           o_MD_Read,
  output logic           o_ReadRAM,
  output logic           o_WriteRAM,
  output logic           o_run,
  output logic           o_illegal_op
);

  logic       w_rr;
  logic       w_imm;
  logic       w_addr;
  logic       w_ld;
  logic [4:0] w_cs;

  assign w_rr   = (i_opcode == OP_ADD) || (i_opcode == OP_SUB) ||
                  (i_opcode == OP_AND) || (i_opcode == OP_OR);
  assign w_imm  = (i_opcode == OP_ADDI) || (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
  // ld, ldi and st all form an address/constant as Rb(or 0) + C in T3/T4.
  assign w_addr = (i_opcode == OP_LD) || (i_opcode == OP_LDI) || (i_opcode == OP_ST);
  assign w_ld   = (i_opcode == OP_LD);

  assign o_Control_Signals = CSW'(w_cs);

  always_comb begin
    o_enable     = '0;
    o_busSelect  = '0;
    w_cs         = ALU_NONE;
    o_Gra        = 1'b0;
    o_Grb        = 1'b0;
    o_Grc        = 1'b0;
    o_Rin        = 1'b0;
    o_Rout       = 1'b0;
    o_BAout      = 1'b0;
    o_MD_Read    = 1'b0;
    o_ReadRAM    = 1'b0;
    o_WriteRAM   = 1'b0;
    o_illegal_op = 1'b0;
    o_run        = (i_state != ST_RESET) && (i_state != ST_HALT);

    case (i_state)
      ST_T0: begin
        o_busSelect[PC_OUT] = 1'b1;
        o_enable[MARIN]     = 1'b1;
        o_enable[ZIN]       = 1'b1;
        w_cs                = ALU_INCPC;
      end
      ST_T1: begin
        o_busSelect[ZLO_OUT] = 1'b1;
        o_enable[PCIN]       = 1'b1;
        o_enable[MDRIN]      = 1'b1;
        o_MD_Read            = 1'b1;
        o_ReadRAM            = 1'b1;
      end
      ST_T2: begin
        o_busSelect[MDR_OUT] = 1'b1;
        o_enable[IRIN]       = 1'b1;
      end
      ST_T3: begin
        if (w_rr || w_imm) begin
          o_Grb         = 1'b1;
          o_Rout        = 1'b1;
          o_enable[YIN] = 1'b1;
        end else if (w_addr) begin
          o_Grb         = 1'b1;
          o_BAout       = 1'b1;
          o_enable[YIN] = 1'b1;
        end else begin
          o_illegal_op  = !op_is_defined(5'(i_opcode));
        end
      end
      ST_T4: begin
        o_enable[ZIN] = 1'b1;
        if (w_rr) begin
          o_Grc  = 1'b1;
          o_Rout = 1'b1;
          w_cs   = alu_code(5'(i_opcode));
        end else begin
          o_busSelect[C_OUT] = 1'b1;
          w_cs               = w_imm ? alu_code(5'(i_opcode)) : ALU_ADD;
        end
      end
      ST_T5: begin
        o_busSelect[ZLO_OUT] = 1'b1;
        if (w_addr && (i_opcode != OP_LDI)) begin
          o_enable[MARIN] = 1'b1;
        end else begin
          o_Gra = 1'b1;
          o_Rin = 1'b1;
        end
      end
      ST_T6: begin
        o_enable[MDRIN] = 1'b1;
        if (w_ld) begin
          o_MD_Read = 1'b1;
          o_ReadRAM = 1'b1;
        end else begin
          o_Gra  = 1'b1;
          o_Rout = 1'b1;
        end
      end
      ST_T7: begin
        if (w_ld) begin
          o_busSelect[MDR_OUT] = 1'b1;
          o_Gra                = 1'b1;
          o_Rin                = 1'b1;
        end else begin
          o_WriteRAM = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired fetch/decode/execute sequencer: state register, opcode latch, next-state.
// Revision 1.0
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int CSW = 5
) (
  input logic                  clk,
  input logic                  clr,
  control_sequencer_if.master  bus
);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] r_opcode;
  logic           w_mem;

  assign w_mem = (r_opcode == OP_LD) || (r_opcode == OP_ST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_RESET;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      // IR holds the freshly fetched word only at the end of T2.
      if (r_state == ST_T2) begin
        r_opcode <= OPW'(get_opcode(bus.ir));
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: w_next = ST_T0;
      ST_T0:    w_next = bus.stop ? ST_HALT : ST_T1;
      ST_T1:    w_next = ST_T2;
      ST_T2:    w_next = ST_T3;
      ST_T3: begin
        if (r_opcode == OP_HALT) begin
          w_next = ST_HALT;
        end else if ((r_opcode == OP_NOP) || !op_is_defined(5'(r_opcode))) begin
          w_next = ST_T0;
        end else begin
          w_next = ST_T4;
        end
      end
      ST_T4:    w_next = ST_T5;
      ST_T5:    w_next = w_mem ? ST_T6 : ST_T0;
      ST_T6:    w_next = ST_T7;
      ST_T7:    w_next = ST_T0;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_RESET;
    endcase
  end

  ctrl_decode #(
    .OPW (OPW),
    .CSW (CSW)
  ) u_decode (
    .i_state           (r_state),
    .i_opcode          (r_opcode),
    .o_enable          (bus.enable),
    .o_busSelect       (bus.busSelect),
    .o_Control_Signals (bus.Control_Signals),
    .o_Gra             (bus.Gra),
    .o_Grb             (bus.Grb),
    .o_Grc             (bus.Grc),
    .o_Rin             (bus.Rin),
    .o_Rout            (bus.Rout),
    .o_BAout           (bus.BAout),
    .o_MD_Read         (bus.MD_Read),
    .o_ReadRAM         (bus.ReadRAM),
    .o_WriteRAM        (bus.WriteRAM),
    .o_run             (bus.run),
    .o_illegal_op      (bus.illegal_op)
  );

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- randomized instruction streams checked against a per-instruction micro-step table.
// Revision 1.0
`default_nettype none

module tb_control_sequencer;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic        gra, grb, grc, rin, rout, baout, mdrd, rdram, wrram, run, ill;
  } exp_t;

  localparam logic [4:0] T_LD = 5'b00000, T_LDI = 5'b00001, T_ST = 5'b00010;
  localparam logic [4:0] T_ADD = 5'b00011, T_SUB = 5'b00100, T_AND = 5'b00101, T_OR = 5'b00110;
  localparam logic [4:0] T_ADDI = 5'b01100, T_ANDI = 5'b01101, T_ORI = 5'b01110;
  localparam logic [4:0] T_NOP = 5'b11010, T_HALT = 5'b11011;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t seq[$];
  logic [4:0] op_tab [12] = '{T_LD, T_LDI, T_ST, T_ADD, T_SUB, T_AND, T_OR,
                              T_ADDI, T_ANDI, T_ORI, T_NOP, T_HALT};

  always #5 clk = ~clk;

  control_sequencer_if #(.CSW(5)) bus ();

  control_sequencer #(.OPW(5), .CSW(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  function automatic exp_t observed();
    return {bus.enable, bus.busSelect, bus.Control_Signals, bus.Gra, bus.Grb, bus.Grc,
            bus.Rin, bus.Rout, bus.BAout, bus.MD_Read, bus.ReadRAM, bus.WriteRAM,
            bus.run, bus.illegal_op};
  endfunction

  task automatic chk(input string tag, input exp_t got, input exp_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  function automatic exp_t active();
    exp_t e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic logic [4:0] ref_alu(input logic [4:0] op);
    if (op == T_ADD || op == T_ADDI) return 5'd1;
    if (op == T_SUB)                 return 5'd2;
    if (op == T_AND || op == T_ANDI) return 5'd3;
    if (op == T_OR  || op == T_ORI)  return 5'd4;
    return 5'd0;
  endfunction

  // Expected strobe list for one instruction, one entry per clock from T0.
  task automatic build(input logic [4:0] op, input bit stop_t0);
    exp_t e;
    bit rr, imm, adr;
    rr  = (op == T_ADD || op == T_SUB || op == T_AND || op == T_OR);
    imm = (op == T_ADDI || op == T_ANDI || op == T_ORI);
    adr = (op == T_LD || op == T_LDI || op == T_ST);
    seq.delete();
    e = active(); e.bs[20] = 1; e.en[25] = 1; e.en[18] = 1; e.cs = 5'd14; seq.push_back(e);
    if (stop_t0) return;
    e = active(); e.bs[19] = 1; e.en[20] = 1; e.en[21] = 1; e.mdrd = 1; e.rdram = 1; seq.push_back(e);
    e = active(); e.bs[21] = 1; e.en[24] = 1; seq.push_back(e);
    if (!(rr || imm || adr)) begin
      e = active();
      e.ill = !(op == T_NOP || op == T_HALT);
      seq.push_back(e);
      return;
    end
    e = active(); e.grb = 1; e.en[19] = 1;
    if (adr) e.baout = 1; else e.rout = 1;
    seq.push_back(e);
    e = active(); e.en[18] = 1;
    if (rr) begin e.grc = 1; e.rout = 1; e.cs = ref_alu(op); end
    else begin e.bs[23] = 1; e.cs = imm ? ref_alu(op) : 5'd1; end
    seq.push_back(e);
    e = active(); e.bs[19] = 1;
    if (op == T_LD || op == T_ST) e.en[25] = 1; else begin e.gra = 1; e.rin = 1; end
    seq.push_back(e);
    if (op == T_LD) begin
      e = active(); e.mdrd = 1; e.rdram = 1; e.en[21] = 1; seq.push_back(e);
      e = active(); e.bs[21] = 1; e.gra = 1; e.rin = 1; seq.push_back(e);
    end else if (op == T_ST) begin
      e = active(); e.gra = 1; e.rout = 1; e.en[21] = 1; seq.push_back(e);
      e = active(); e.wrram = 1; seq.push_back(e);
    end
  endtask

  // IR carries the real instruction only in T2; other cycles show junk to expose a mistimed latch.
  task automatic exec_instr(input logic [4:0] op, input bit stop_t0, input int clr_at);
    logic [31:0] word;
    word = {op, 27'($urandom)};
    build(op, stop_t0);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      bus.ir   = (i == 2) ? word : $urandom;
      bus.stop = (i == 0) ? stop_t0 : 1'($urandom);
      chk($sformatf("op%b_step%0d", op, i), observed(), seq[i]);
      if (i == clr_at) begin
        #2 clr = 1'b0;
        #1 chk($sformatf("op%b_async_clr", op), observed(), '0);
        break;
      end
    end
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ir   = $urandom;
      bus.stop = 1'($urandom);
      chk($sformatf("halted_%0d", i), observed(), '0);
    end
  endtask

  task automatic do_clr(input bit already_low);
    if (!already_low) begin
      @(negedge clk);
      clr = 1'b0;
      #1 chk("clr_low", observed(), '0);
    end
    @(negedge clk);
    chk("clr_hold", observed(), '0);
    clr = 1'b1;
    #1 chk("reset_cycle", observed(), '0);
  endtask

  initial begin
    logic [4:0] op;
    bit         st;
    clr      = 1'b0;
    bus.ir   = '0;
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", observed(), '0);
    clr = 1'b1;
    #1 chk("reset_release", observed(), '0);

    exec_instr(T_ADDI, 1'b0, -1);
    exec_instr(T_LD, 1'b0, -1);
    exec_instr(T_ST, 1'b0, -1);
    exec_instr(5'b11111, 1'b0, -1);
    exec_instr(T_NOP, 1'b0, -1);
    exec_instr(T_LD, 1'b0, 6);
    do_clr(1'b1);
    exec_instr(T_ADD, 1'b1, -1);
    halt_idle(3);
    do_clr(1'b0);
    exec_instr(T_HALT, 1'b0, -1);
    halt_idle(20);
    do_clr(1'b0);

    for (int n = 0; n < 120; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 11)];
      st = ($urandom_range(0, 15) == 0);
      exec_instr(op, st, -1);
      if (st || op == T_HALT) begin
        halt_idle($urandom_range(1, 4));
        do_clr(1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit sitting directly upstream of the datapath.
- Generates every per-cycle control strobe that the datapath consumes: the enable and busSelect one-hot vectors, Control_Signals, Gra/Grb/Grc/Rin/Rout/BAout, MD_Read, ReadRAM and WriteRAM.
- Steps fetch, decode and execute states from the IR value the datapath returns, replacing hand-driven T-state stimulus.
- Supports ld, ldi, st, reg-reg ALU, ALU-immediate, nop and halt.

Parameters:
- OPW, 5, opcode field width (ir[31:27]).
- CSW, 5, width of Control_Signals.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- ir  in  32  instruction register contents from the datapath.
- stop  in  1  halt request, sampled only in T0.
- enable  out  32  datapath register-load one-hots. Bits used: 18 Zin, 19 Yin, 20 PCin, 21 MDRin, 24 IRin, 25 MARin. Bits 0-15 are always 0; register loads go via Rin.
- busSelect  out  32  bus source one-hots. Bits used: 19 ZLowout, 20 PCout, 21 MDRout, 23 Cout.
- Control_Signals  out  5  ALU op: 0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 14 INCPC.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes.
- MD_Read, ReadRAM, WriteRAM  out  1 each  memory/MDR strobes.
- run  out  1  high while sequencing.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- State register is updated on posedge clk. All outputs are Moore-decoded from state plus the latched opcode, so they are stable for the whole cycle.
- States: RESET, T0..T7, HALT.
- clr low, at any time including mid-instruction: state goes to RESET immediately. All outputs are 0, including run.
- RESET leads to T0 on the first edge after clr releases.
- Fetch, identical for every instruction:
  - T0: busSelect[20], enable[25], CS=14, enable[18].
  - T1: busSelect[19], enable[20], enable[21], MD_Read, ReadRAM.
  - T2: busSelect[21], enable[24].
- Opcode is latched from ir[31:27] on the T2 to T3 edge. Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - nop 11010, halt 11011
- Reg-reg ALU (add, sub, and, or):
  - T3: Grb, Rout, enable[19].
  - T4: Grc, Rout, CS=op, enable[18].
  - T5: busSelect[19], Gra, Rin. Then T0.
- ALU-immediate (addi, andi, ori):
  - T3: Grb, Rout, enable[19].
  - T4: busSelect[23], CS=op, enable[18].
  - T5: busSelect[19], Gra, Rin. Then T0.
- ldi:
  - T3: Grb, BAout, enable[19].
  - T4: busSelect[23], CS=1, enable[18].
  - T5: busSelect[19], Gra, Rin. Then T0.
- ld:
  - T3 and T4 as ldi.
  - T5: busSelect[19], enable[25].
  - T6: MD_Read, ReadRAM, enable[21].
  - T7: busSelect[21], Gra, Rin. Then T0.
- st:
  - T3 to T5 as ld.
  - T6: Gra, Rout, enable[21] with MD_Read=0 (MDR loads from bus).
  - T7: WriteRAM. Then T0.
- nop: T3 drives no strobes, then T0.
- halt: T3 goes to HALT. HALT drives all outputs 0 and run=0, and is left only via clr.
- stop high while in T0: T0 strobes are still driven that cycle, then next state is HALT. stop in any other state is ignored.
- Undefined opcode: T3 pulses illegal_op, behaves as nop, then T0.
- run is 1 in T0..T7 and 0 in RESET and HALT.
- At most one busSelect bit is high in any cycle. Unlisted bits are always 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALU op codes (1, 2, 3, 4, 14);
  - enable and busSelect bit-index constants (ZIN=18, YIN=19, PCIN=20, MDRIN=21, IRIN=24, MARIN=25, ZLO_OUT=19, PC_OUT=20, MDR_OUT=21, C_OUT=23).
- One natural sub-module, ctrl_decode: purely combinational mapping of (state, opcode) to the output vectors. control_sequencer keeps the state register, opcode latch and next-state logic.

Test Plan:
- Reset then addi: ir=0x6000_0000|fields, i.e. opcode 01100. Cycle order T0→T5 then T0. T4 shows busSelect[23]=1, CS=1, enable[18]=1. run=1 throughout.
- ld: opcode 00000. Exactly 8 cycles T0..T7. T6 shows MD_Read=ReadRAM=enable[21]=1. T7 shows busSelect[21]=Gra=Rin=1.
- st: opcode 00010. T6 shows Gra=Rout=enable[21]=1 with MD_Read=0. T7 shows WriteRAM=1 and all other strobes 0.
- halt: opcode 11011. After T3, state is HALT, run=0 and all outputs 0 for 20 cycles. clr pulse low then T0 resumes.
- Illegal opcode 11111: illegal_op=1 for exactly the T3 cycle, then T0.
- clr asserted asynchronously mid-T6 of ld: outputs drop to 0 before the next edge. After release, the first cycle is RESET, then T0.
- stop=1 during T0: T0 strobes are asserted, then HALT.
